decoder_rr_arbiter: RTL
=======================

# decoder_rr_arbiter

Eight-requester round-robin arbiter that sequences the gate-level 3-to-8 decoder. It selects one requester at a time, drives the decoder's select inputs (A, B, C) and enable inputs (G1, G2AN, G3BN), and holds the grant until the requester releases it or a hold-time limit expires. The active-low decoder output Y0..Y7 for the chosen index is the per-requester grant. Every requester is guaranteed a one-cycle break-before-make gap between grants.

## Interface
- MAX_HOLD, 15: maximum cycles a grant may be held. Legal range 0..255; 0 = unlimited.
- CLK  input  1  rising-edge clock.
- RSTN  input  1  asynchronous, active-low reset.
- REQ  input  8  request vector; REQ[i] high = requester i wants the decoder.
- REL  input  1  one-cycle release strobe from the current grant holder.
- A  output  1  decoder select MSB (index bit 2).
- B  output  1  decoder select (index bit 1).
- C  output  1  decoder select LSB (index bit 0).
- G1  output  1  decoder enable, active high.
- G2AN  output  1  decoder enable, active low.
- G3BN  output  1  decoder enable, active low.
- BUSY  output  1  high while a grant is active (equals G1).
- TIMEOUT  output  1  one-cycle pulse when a grant is force-released by MAX_HOLD.

## Operation
- All outputs are registered.
- Reset values: A=B=C=0, G1=0, G2AN=1, G3BN=1, BUSY=0, TIMEOUT=0, pointer PTR=0, hold counter 0, state IDLE.
- FSM states: IDLE, GRANT, GAP.
- IDLE:
  - If REQ==0, stay in IDLE.
  - Otherwise pick the first i with REQ[i]=1, searching circularly from PTR (PTR, PTR+1, … wrapping 7→0).
  - Load {A,B,C}=i, set G1=1, G2AN=0, G3BN=0, hold counter=1, and go to GRANT.
- GRANT: release when any of the following is true at a clock edge:
  - REL=1;
  - REQ[granted] = 0;
  - MAX_HOLD≠0, counter==MAX_HOLD, and neither condition above holds. This is a forced release: TIMEOUT=1 for one cycle.
- GRANT, no release: counter increments, saturating at 255.
- On release:
  - G1=0, G2AN=1, G3BN=1.
  - {A,B,C} keep their value.
  - PTR = granted+1 mod 8.
  - Go to GAP.
- GAP: all enables deasserted for exactly one cycle; REQ is ignored. Then go to IDLE.
- Priority of simultaneous events:
  - REL or a dropped request, in the same cycle as timeout → normal release, no TIMEOUT pulse.
  - New REQ bits during GRANT do not pre-empt the holder.
- Reset asserted mid-grant: enables go to their disabled values immediately (asynchronously), and all state returns to reset values. PTR returns to 0.

## Timing
- Grant latency: REQ is sampled high at edge t while in IDLE. A/B/C/G1 are valid after edge t, and the decoder output Y[i] goes low in cycle t+1.
- Release latency:
  - REL sampled at edge t → enables drop after edge t.
  - GAP occupies cycle t+1.
  - IDLE occupies cycle t+2.
  - Earliest next grant is valid after edge t+2.
- Forced release: with a continuously held request, the grant is active for exactly MAX_HOLD cycles.
- Grant-to-grant minimum spacing: 2 disabled cycles (GAP + IDLE).
- A/B/C never change while G1=1. Select changes only when leaving IDLE, so the decoder never glitches onto a wrong output.

## Structure
- Shared package:
  - state enum (IDLE, GRANT, GAP);
  - index width constant (3);
  - requester count constant (8);
  - hold-counter width constant (8).
- Sub-module rr_pick8: combinational circular priority picker.
  - Inputs: REQ[7:0], PTR[2:0].
  - Outputs: index[2:0], any.
- Top module contains the FSM, PTR register, hold counter and output registers.
- The decoder itself is instanced by the integrating level, not inside this block.

## Test plan
- Reset: assert RSTN=0 during an active grant → G1=0, G2AN=1, G3BN=1, A=B=C=0, BUSY=0 immediately. After release with REQ=0x00, outputs stay idle.
- Single request: REQ=0x10 → {A,B,C}=100, G1=1 one cycle later, decoder Y4 low. REL pulse → Y4 high, and exactly 2 idle cycles follow.
- Fairness: REQ=0xFF constant, REL pulsed every third grant cycle → grant order 0,1,2,3,4,5,6,7,0, with PTR wrapping 7→0.
- Timeout: MAX_HOLD=4, REQ=0x03 held, no REL → index 0 granted for 4 cycles, TIMEOUT pulses once, then index 1 granted after 2 disabled cycles.
- Simultaneous events: MAX_HOLD=4, REL asserted on the 4th grant cycle → release with TIMEOUT=0. Requester drop (REQ=0x20→0x00) mid-grant → release the next cycle.
- Unlimited hold: MAX_HOLD=0, REQ=0x80 held for 300 cycles → grant held throughout, TIMEOUT never asserts, counter saturates without wrap.

Source files
------------

// File: rtl/decoder_rr_arbiter_pkg.sv
// decoder_rr_arbiter_pkg: shared FSM state type and sizing constants for the decoder arbiter
package decoder_rr_arbiter_pkg;
   localparam int IDX_W = 3;
   localparam int N_REQ = 8;
   localparam int CNT_W = 8;
   typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;
endpackage

// File: rtl/decoder_rr_arbiter_if.sv
// decoder_rr_arbiter_if: request/release inputs and decoder select/enable outputs
//   req[7:0], rel      : from requesters to arbiter
//   a, b, c            : decoder select (a = index bit 2, c = index bit 0)
//   g1, g2an, g3bn     : decoder enables (g1 active high, g2an/g3bn active low)
//   busy, timeout      : grant active, one-cycle forced-release pulse
interface decoder_rr_arbiter_if;
   import decoder_rr_arbiter_pkg::*;
   logic [N_REQ-1:0] req;
   logic             rel;
   logic             a;
   logic             b;
   logic             c;
   logic             g1;
   logic             g2an;
   logic             g3bn;
   logic             busy;
   logic             timeout;
   modport master (output req, rel, input a, b, c, g1, g2an, g3bn, busy, timeout);
   modport slave (input req, rel, output a, b, c, g1, g2an, g3bn, busy, timeout);
endinterface

// File: rtl/decoder_rr_arbiter_rr_pick8.sv
// rr_pick8: combinational circular priority picker, first set req bit at or after ptr
//   req[7:0] in, ptr[2:0] in, index[2:0] out, any out
module rr_pick8
   import decoder_rr_arbiter_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   output logic [IDX_W-1:0] index,
   output logic             any
);
   logic [IDX_W-1:0] cand;
   always_comb begin
      index = '0;
      cand  = '0;
      // Scan from the farthest offset down so the nearest hit to ptr wins.
      for (int i = N_REQ - 1; i >= 0; i--) begin
         cand = ptr + i[IDX_W-1:0];
         if (req[cand]) index = cand;
      end
      any = |req;
   end
endmodule

// File: rtl/decoder_rr_arbiter.sv
// decoder_rr_arbiter: 8-way round-robin arbiter sequencing a 3-to-8 decoder's select/enables
//   clk, rst_n (async active-low), bus (slave modport): req, rel in; a, b, c, g1, g2an, g3bn, busy, timeout out
module decoder_rr_arbiter
   import decoder_rr_arbiter_pkg::*;
#(
   parameter int MAX_HOLD = 15
) (
   input  logic                 clk,
   input  logic                 rst_n,
   decoder_rr_arbiter_if.slave  bus
);
   localparam logic [CNT_W-1:0] MAX_H = CNT_W'(MAX_HOLD);
   state_t           state, state_n;
   logic [IDX_W-1:0] ptr, ptr_n, sel, sel_n, pick;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic             en, en_n, dis, dis_n, to, to_n;
   logic             any, drop, expire;
   rr_pick8 u_pick (
      .req   (bus.req),
      .ptr   (ptr),
      .index (pick),
      .any   (any)
   );
   always_comb begin
      state_n = state;
      ptr_n   = ptr;
      cnt_n   = cnt;
      sel_n   = sel;
      en_n    = en;
      dis_n   = dis;
      to_n    = 1'b0;
      drop    = bus.rel | ~bus.req[sel];
      // A voluntary release in the same cycle takes precedence over the hold limit.
      expire  = (MAX_H != '0) && (cnt == MAX_H) && !drop;
      case (state)
         IDLE: begin
            if (any) begin
               state_n = GRANT;
               sel_n   = pick;
               en_n    = 1'b1;
               dis_n   = 1'b0;
               cnt_n   = CNT_W'(1);
            end
         end
         GRANT: begin
            if (drop || expire) begin
               state_n = GAP;
               en_n    = 1'b0;
               dis_n   = 1'b1;
               ptr_n   = sel + IDX_W'(1);
               to_n    = expire;
            end else begin
               cnt_n = (cnt == '1) ? cnt : cnt + CNT_W'(1);
            end
         end
         default: state_n = IDLE;
      endcase
   end
   // Select only moves when leaving IDLE, so it is stable for the whole grant and gap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         ptr   <= '0;
         cnt   <= '0;
         sel   <= '0;
         en    <= 1'b0;
         dis   <= 1'b1;
         to    <= 1'b0;
      end else begin
         state <= state_n;
         ptr   <= ptr_n;
         cnt   <= cnt_n;
         sel   <= sel_n;
         en    <= en_n;
         dis   <= dis_n;
         to    <= to_n;
      end
   end
   assign bus.a       = sel[2];
   assign bus.b       = sel[1];
   assign bus.c       = sel[0];
   assign bus.g1      = en;
   assign bus.g2an    = dis;
   assign bus.g3bn    = dis;
   assign bus.busy    = en;
   assign bus.timeout = to;
endmodule
